// File: rtl/fft_reorder.sv
// Output reorder buffer for the R22SDF FFT core: turns the core's bit-reversed
// frame stream into natural frequency order using a two-bank ping-pong memory.
module fft_reorder #(
  parameter int WIDTH   = 16,
  parameter int LOG2N   = 6,
  parameter int REORDER = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  input  logic             do_rdy,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             do_first,
  output logic             do_last,
  output logic             ovf
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] CNT_ONE = LOG2N'(1);

  // Output handshake: a sample transfers on a rising edge where do_en and
  // do_rdy are both high; while do_en is high and do_rdy low, every output
  // holds. The input side has no ready: samples are taken or dropped.

  logic [2*WIDTH-1:0] mem_q [0:2*N-1];

  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic             rbank_q, rbank_d;
  logic [1:0]       full_q, full_d;
  logic             discard_q, discard_d;
  logic             ovf_q, ovf_d;
  logic             do_en_q, do_en_d;
  logic [WIDTH-1:0] do_re_q, do_re_d;
  logic [WIDTH-1:0] do_im_q, do_im_d;
  logic             do_first_q, do_first_d;
  logic             do_last_q, do_last_d;

  logic [LOG2N-1:0] brev;
  logic [LOG2N-1:0] waddr;
  logic             wfirst, wlast, drop, wr_en;
  logic             advance, rd_fire, rlast;

  always_comb begin
    brev = '0;
    for (int b = 0; b < LOG2N; b++) brev[b] = wcnt_q[LOG2N-1-b];
  end

  assign waddr   = (REORDER != 0) ? brev : wcnt_q;
  assign wfirst  = (wcnt_q == '0);
  assign wlast   = (wcnt_q == CNT_MAX);
  // A frame is refused only at its first sample; once refused, the rest of it goes too.
  assign drop    = discard_q | (wfirst & full_q[wbank_q]);
  assign wr_en   = di_en & ~drop;
  assign advance = ~do_en_q | do_rdy;
  assign rd_fire = advance & full_q[rbank_q];
  assign rlast   = (rcnt_q == CNT_MAX);

  always_comb begin
    wcnt_d     = wcnt_q;
    wbank_d    = wbank_q;
    rcnt_d     = rcnt_q;
    rbank_d    = rbank_q;
    full_d     = full_q;
    discard_d  = discard_q;
    ovf_d      = ovf_q;
    do_en_d    = do_en_q;
    do_re_d    = do_re_q;
    do_im_d    = do_im_q;
    do_first_d = do_first_q;
    do_last_d  = do_last_q;

    if (di_en) begin
      wcnt_d = wcnt_q + CNT_ONE;
      if (wfirst && full_q[wbank_q]) begin
        discard_d = 1'b1;
        ovf_d     = 1'b1;
      end
      if (wlast) begin
        if (discard_q) begin
          discard_d = 1'b0;
        end else begin
          full_d[wbank_q] = 1'b1;
          wbank_d         = ~wbank_q;
        end
      end
    end

    // Writer set and reader clear always target different banks.
    if (advance) begin
      if (full_q[rbank_q]) begin
        do_en_d                = 1'b1;
        {do_re_d, do_im_d}     = mem_q[{rbank_q, rcnt_q}];
        do_first_d             = (rcnt_q == '0);
        do_last_d              = rlast;
        rcnt_d                 = rcnt_q + CNT_ONE;
        if (rlast) begin
          full_d[rbank_q] = 1'b0;
          rbank_d         = ~rbank_q;
        end
      end else begin
        do_en_d    = 1'b0;
        do_first_d = 1'b0;
        do_last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wcnt_q     <= '0;
      wbank_q    <= 1'b0;
      rcnt_q     <= '0;
      rbank_q    <= 1'b0;
      full_q     <= 2'b00;
      discard_q  <= 1'b0;
      ovf_q      <= 1'b0;
      do_en_q    <= 1'b0;
      do_re_q    <= '0;
      do_im_q    <= '0;
      do_first_q <= 1'b0;
      do_last_q  <= 1'b0;
    end else begin
      wcnt_q     <= wcnt_d;
      wbank_q    <= wbank_d;
      rcnt_q     <= rcnt_d;
      rbank_q    <= rbank_d;
      full_q     <= full_d;
      discard_q  <= discard_d;
      ovf_q      <= ovf_d;
      do_en_q    <= do_en_d;
      do_re_q    <= do_re_d;
      do_im_q    <= do_im_d;
      do_first_q <= do_first_d;
      do_last_q  <= do_last_d;
    end
  end

  // Sample storage is never reset; stale contents are unreachable until rewritten.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[{wbank_q, waddr}] <= {di_re, di_im};
  end

  assign do_en    = do_en_q;
  assign do_re    = do_re_q;
  assign do_im    = do_im_q;
  assign do_first = do_first_q;
  assign do_last  = do_last_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_fft_reorder.sv
// Bench for fft_reorder: one bit-reversing and one natural-order instance share
// the input stream; each output stream is scored against a frame-level model.
module tb_fft_reorder;

  localparam int W  = 16;
  localparam int L  = 6;
  localparam int N  = 1 << L;
  localparam int EW = 2 * W + 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         di_en = 1'b0;
  logic [W-1:0] di_re = '0;
  logic [W-1:0] di_im = '0;
  logic         do_rdy = 1'b0;

  logic         do_en_r1, do_first_r1, do_last_r1, ovf_r1;
  logic [W-1:0] do_re_r1, do_im_r1;
  logic         do_en_r0, do_first_r0, do_last_r0, ovf_r0;
  logic [W-1:0] do_re_r0, do_im_r0;

  fft_reorder #(.WIDTH(W), .LOG2N(L), .REORDER(1)) u_rev (
    .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_rdy(do_rdy), .do_en(do_en_r1), .do_re(do_re_r1), .do_im(do_im_r1),
    .do_first(do_first_r1), .do_last(do_last_r1), .ovf(ovf_r1)
  );

  fft_reorder #(.WIDTH(W), .LOG2N(L), .REORDER(0)) u_nat (
    .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_rdy(do_rdy), .do_en(do_en_r0), .do_re(do_re_r0), .do_im(do_im_r0),
    .do_first(do_first_r0), .do_last(do_last_r0), .ovf(ovf_r0)
  );

  // clock / reset
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit rand_rdy = 1'b0;

  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q0[$];
  int runs_q[$];
  int run_len = 0;
  int rise_cyc = -1;
  int n_acc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bitrev(input int k);
    int r = 0;
    int x = k;
    for (int b = 0; b < L; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  // scoreboard / monitor
  logic [EW:0] cur1, cur0, prev1, prev0;
  bit stall1 = 1'b0;
  bit stall0 = 1'b0;

  always @(negedge clock) begin
    cur1 = {do_en_r1, do_first_r1, do_last_r1, do_re_r1, do_im_r1};
    cur0 = {do_en_r0, do_first_r0, do_last_r0, do_re_r0, do_im_r0};
    if (!reset) begin
      stall1 = 1'b0;
      stall0 = 1'b0;
      if (run_len > 0) runs_q.push_back(run_len);
      run_len = 0;
    end else begin
      if (stall1) chk("stall_hold_rev", cur1, prev1);
      if (stall0) chk("stall_hold_nat", cur0, prev0);
      if (do_en_r1) begin
        if (run_len == 0) rise_cyc = cyc;
        run_len++;
      end else if (run_len > 0) begin
        runs_q.push_back(run_len);
        run_len = 0;
      end
      if (do_en_r1 && do_rdy) begin
        if (exp_q1.size() == 0) chk("spurious_rev", do_en_r1, 0);
        else chk("data_rev", cur1[EW-1:0], exp_q1.pop_front());
        n_acc++;
      end
      if (do_en_r0 && do_rdy) begin
        if (exp_q0.size() == 0) chk("spurious_nat", do_en_r0, 0);
        else chk("data_nat", cur0[EW-1:0], exp_q0.pop_front());
      end
      stall1 = do_en_r1 && !do_rdy;
      stall0 = do_en_r0 && !do_rdy;
    end
    prev1 = cur1;
    prev0 = cur0;
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_rdy) do_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input bit ramp, input int gap_mode, input bit kept, output int last_in);
    logic [W-1:0] re_a[N];
    logic [W-1:0] im_a[N];
    int src;
    for (int j = 0; j < N; j++) begin
      re_a[j] = ramp ? W'(j) : W'($urandom);
      im_a[j] = ramp ? W'(-j) : W'($urandom);
    end
    if (kept) begin
      for (int k = 0; k < N; k++) begin
        src = bitrev(k);
        exp_q1.push_back({k == 0, k == N - 1, re_a[src], im_a[src]});
        exp_q0.push_back({k == 0, k == N - 1, re_a[k], im_a[k]});
      end
    end
    last_in = 0;
    for (int j = 0; j < N; j++) begin
      di_en = 1'b1;
      di_re = re_a[j];
      di_im = im_a[j];
      tick();
      di_en = 1'b0;
      di_re = W'($urandom);
      di_im = W'($urandom);
      if (j == N - 1) last_in = cyc;
      else if (gap_mode == 1) repeat (2) tick();
      else if (gap_mode == 2) repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && (exp_q1.size() != 0 || exp_q0.size() != 0); i++) tick();
    chk("drain_rev", exp_q1.size(), 0);
    chk("drain_nat", exp_q0.size(), 0);
    repeat (3) tick();
  endtask

  task automatic check_runs(input string tag, input int len, input int exp_rise);
    chk({tag, "_runs"}, runs_q.size(), 1);
    chk({tag, "_len"}, runs_q[0], len);
    chk({tag, "_latency"}, rise_cyc, exp_rise);
  endtask

  initial begin
    int last_in;
    int first_last;
    int acc0;

    // reset held low while inputs toggle
    repeat (4) begin
      tick();
      di_en  = 1'($urandom_range(0, 1));
      di_re  = W'($urandom);
      di_im  = W'($urandom);
      do_rdy = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    chk("rst_en", do_en_r1, 0);
    chk("rst_re", do_re_r1, 0);
    chk("rst_im", do_im_r1, 0);
    chk("rst_first", do_first_r1, 0);
    chk("rst_last", do_last_r1, 0);
    chk("rst_ovf", ovf_r1, 0);
    chk("rst_en_nat", do_en_r0, 0);
    chk("rst_ovf_nat", ovf_r0, 0);
    tick();
    di_en  = 1'b0;
    do_rdy = 1'b1;
    reset  = 1'b1;
    repeat (2) tick();

    // single ramp frame
    runs_q.delete();
    send_frame(1'b1, 0, 1'b1, last_in);
    wait_drain();
    check_runs("single", N, last_in + 1);
    chk("single_ovf", ovf_r1, 0);

    // three back-to-back random frames
    runs_q.delete();
    send_frame(1'b0, 0, 1'b1, first_last);
    send_frame(1'b0, 0, 1'b1, last_in);
    send_frame(1'b0, 0, 1'b1, last_in);
    wait_drain();
    check_runs("b2b", 3 * N, first_last + 1);
    chk("b2b_ovf", ovf_r1, 0);

    // input valid one cycle in three
    runs_q.delete();
    send_frame(1'b0, 1, 1'b1, last_in);
    wait_drain();
    check_runs("gapped", N, last_in + 1);

    // random gaps with random downstream ready, never overfilling
    rand_rdy = 1'b1;
    repeat (5) begin
      for (int i = 0; i < 3000 && exp_q1.size() > N; i++) tick();
      chk("room_wait", exp_q1.size() > N, 0);
      send_frame(1'b0, 2, 1'b1, last_in);
    end
    rand_rdy = 1'b0;
    do_rdy   = 1'b1;
    wait_drain();
    chk("random_ovf", ovf_r1, 0);
    chk("random_ovf_nat", ovf_r0, 0);

    // backpressure: third frame has no free bank
    do_rdy = 1'b0;
    tick();
    acc0 = n_acc;
    send_frame(1'b0, 0, 1'b1, last_in);
    send_frame(1'b0, 0, 1'b1, last_in);
    send_frame(1'b0, 0, 1'b0, last_in);
    repeat (10) tick();
    chk("bp_ovf", ovf_r1, 1);
    chk("bp_ovf_nat", ovf_r0, 1);
    chk("bp_stall_en", do_en_r1, 1);
    chk("bp_none_taken", n_acc - acc0, 0);
    do_rdy = 1'b1;
    wait_drain();
    chk("bp_count", n_acc - acc0, 2 * N);
    chk("bp_idle", do_en_r1, 0);
    chk("bp_ovf_sticky", ovf_r1, 1);

    // reset clears overflow and abandons a partial frame
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("rst2_ovf", ovf_r1, 0);
    chk("rst2_ovf_nat", ovf_r0, 0);
    for (int j = 0; j < 30; j++) begin
      di_en = 1'b1;
      di_re = W'($urandom);
      di_im = W'($urandom);
      tick();
    end
    di_en = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    runs_q.delete();
    send_frame(1'b1, 0, 1'b1, last_in);
    wait_drain();
    check_runs("post_rst", N, last_in + 1);
    chk("post_rst_ovf", ovf_r1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
